// File: rtl/control_unit_pkg.sv
// Shared state encoding, opcode values and ALU operation codes for the control unit.
package control_unit_pkg;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    NOOP   = 4'd3,
    LOAD_A = 4'd4,
    LOAD_B = 4'd5,
    STORE  = 4'd6,
    ADD    = 4'd7,
    SUB    = 4'd8,
    JUMP   = 4'd9,
    HALT   = 4'd10
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_JMP   = 4'd6;
  localparam logic [3:0] OP_JZ    = 4'd7;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // Opcode nibble plus the widest operand layout (three registers, or address + register).
  function automatic int instr_width(input int r_w, input int d_w);
    return 4 + ((3 * r_w > d_w + r_w) ? 3 * r_w : d_w + r_w);
  endfunction

endpackage

// File: rtl/control_unit_fsm.sv
// Control FSM: state register, next-state logic and Moore output decode from state and IR.
module control_unit_fsm
  import control_unit_pkg::*;
#(
  parameter int R_W = 4,
  parameter int D_W = 8,
  localparam int INSTR_W = instr_width(R_W, D_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic               resume,
  input  logic [INSTR_W-1:0] ir,
  output logic [3:0]         state,
  output logic [3:0]         next_state,
  output logic [D_W-1:0]     d_addr,
  output logic               d_wr,
  output logic               rf_s,
  output logic               rf_w_en,
  output logic [R_W-1:0]     rf_ra_addr,
  output logic [R_W-1:0]     rf_rb_addr,
  output logic [R_W-1:0]     rf_w_addr,
  output logic [2:0]         alu_s0,
  output logic               halted
);

  localparam int TOP = INSTR_W - 5;

  state_t st, nx;

  logic [3:0]     opcode;
  logic [R_W-1:0] fld_ra, fld_rb, fld_w, fld_mem_reg;
  logic [D_W-1:0] fld_mem_addr;

  // Operand fields sit directly below the opcode, MSB-first.
  assign opcode       = ir[INSTR_W-1 -: 4];
  assign fld_ra       = ir[TOP -: R_W];
  assign fld_rb       = ir[TOP-R_W -: R_W];
  assign fld_w        = ir[TOP-2*R_W -: R_W];
  assign fld_mem_addr = ir[TOP -: D_W];
  assign fld_mem_reg  = ir[TOP-D_W -: R_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= INIT;
    else        st <= nx;
  end

  always_comb begin
    nx         = st;
    d_addr     = '0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_en    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    rf_w_addr  = '0;
    alu_s0     = ALU_PASS;
    halted     = 1'b0;
    case (st)
      INIT:   nx = FETCH;
      FETCH:  if (i_valid) nx = DECODE;
      DECODE: begin
        case (opcode)
          OP_STORE:      nx = STORE;
          OP_LOAD:       nx = LOAD_A;
          OP_ADD:        nx = ADD;
          OP_SUB:        nx = SUB;
          OP_HALT:       nx = HALT;
          OP_JMP, OP_JZ: nx = JUMP;
          default:       nx = NOOP;
        endcase
      end
      NOOP:   nx = FETCH;
      LOAD_A, LOAD_B: begin
        d_addr    = fld_mem_addr;
        rf_w_addr = fld_mem_reg;
        rf_s      = 1'b1;
        rf_w_en   = (st == LOAD_B);
        nx        = (st == LOAD_A) ? LOAD_B : FETCH;
      end
      STORE: begin
        d_addr     = fld_mem_addr;
        rf_ra_addr = fld_mem_reg;
        d_wr       = 1'b1;
        nx         = FETCH;
      end
      ADD, SUB: begin
        rf_ra_addr = fld_ra;
        rf_rb_addr = fld_rb;
        rf_w_addr  = fld_w;
        alu_s0     = (st == ADD) ? ALU_ADD : ALU_SUB;
        rf_w_en    = 1'b1;
        nx         = FETCH;
      end
      JUMP:   nx = FETCH;
      HALT: begin
        halted = 1'b1;
        if (resume) nx = FETCH;
      end
      default: nx = INIT;
    endcase
  end

  assign state      = st;
  assign next_state = nx;

endmodule

// File: rtl/control_unit_param.sv
// Processor control unit top: owns PC, IR and zero flag; sequencing lives in control_unit_fsm.
module control_unit_param
  import control_unit_pkg::*;
#(
  parameter int PC_W = 7,
  parameter int R_W  = 4,
  parameter int D_W  = 8,
  localparam int INSTR_W = instr_width(R_W, D_W)
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic [INSTR_W-1:0] I_Data,
  input  logic               I_Valid,
  input  logic               ALU_Zero,
  input  logic               Resume,
  output logic [PC_W-1:0]    I_Addr,
  output logic [PC_W-1:0]    PC_Out,
  output logic [INSTR_W-1:0] IR_Out,
  output logic [3:0]         OutState,
  output logic [3:0]         NextState,
  output logic [D_W-1:0]     D_Addr,
  output logic               D_Wr,
  output logic               RF_s,
  output logic               RF_W_en,
  output logic [R_W-1:0]     RF_Ra_Addr,
  output logic [R_W-1:0]     RF_Rb_Addr,
  output logic [R_W-1:0]     RF_W_Addr,
  output logic [2:0]         ALU_s0,
  output logic               Halted
);

  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               z;
  logic [3:0]         state;
  logic               take_branch;

  control_unit_fsm #(.R_W(R_W), .D_W(D_W)) u_fsm (
    .clk        (Clk),
    .rst_n      (ResetN),
    .i_valid    (I_Valid),
    .resume     (Resume),
    .ir         (ir),
    .state      (state),
    .next_state (NextState),
    .d_addr     (D_Addr),
    .d_wr       (D_Wr),
    .rf_s       (RF_s),
    .rf_w_en    (RF_W_en),
    .rf_ra_addr (RF_Ra_Addr),
    .rf_rb_addr (RF_Rb_Addr),
    .rf_w_addr  (RF_W_Addr),
    .alu_s0     (ALU_s0),
    .halted     (Halted)
  );

  // JZ sees the flag left by the most recent ADD/SUB.
  assign take_branch = (ir[INSTR_W-1 -: 4] == OP_JMP) ||
                       ((ir[INSTR_W-1 -: 4] == OP_JZ) && z);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      pc <= '0;
      ir <= '0;
      z  <= 1'b0;
    end else begin
      if ((state == FETCH) && I_Valid) begin
        ir <= I_Data;
        pc <= pc + PC_W'(1);
      end
      if ((state == JUMP) && take_branch) pc <= ir[PC_W-1:0];
      if ((state == ADD) || (state == SUB)) z <= ALU_Zero;
    end
  end

  assign I_Addr   = pc;
  assign PC_Out   = pc;
  assign IR_Out   = ir;
  assign OutState = state;

endmodule

// File: tb/tb_control_unit_param.sv
// Randomised instruction-stream bench with a per-instruction reference model of the control unit.
module tb_control_unit_param;

  localparam logic [3:0] S_INIT = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2, S_NOOP = 4'd3,
                         S_LA = 4'd4, S_LB = 4'd5, S_ST = 4'd6, S_ADD = 4'd7,
                         S_SUB = 4'd8, S_JMP = 4'd9, S_HALT = 4'd10;

  logic        Clk = 1'b0, ResetN = 1'b0, I_Valid = 1'b0, ALU_Zero = 1'b0, Resume = 1'b0;
  logic [15:0] I_Data = '0;
  logic [6:0]  I_Addr, PC_Out;
  logic [15:0] IR_Out;
  logic [3:0]  OutState, NextState;
  logic [7:0]  D_Addr;
  logic        D_Wr, RF_s, RF_W_en, Halted;
  logic [3:0]  RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr;
  logic [2:0]  ALU_s0;

  control_unit_param dut (
    .Clk(Clk), .ResetN(ResetN), .I_Data(I_Data), .I_Valid(I_Valid), .ALU_Zero(ALU_Zero),
    .Resume(Resume), .I_Addr(I_Addr), .PC_Out(PC_Out), .IR_Out(IR_Out), .OutState(OutState),
    .NextState(NextState), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
    .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr), .RF_W_Addr(RF_W_Addr),
    .ALU_s0(ALU_s0), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_err = 0;
  logic chk_en = 1'b0;

  // Architectural model state
  logic [6:0]  m_pc;
  logic [15:0] m_ir;
  logic        m_z;

  // Expected outputs for the current cycle
  logic [3:0]  e_state, e_next, e_ra, e_rb, e_wa;
  logic [6:0]  e_pc;
  logic [15:0] e_ir;
  logic [7:0]  e_daddr;
  logic        e_dwr, e_rfs, e_wen, e_halt;
  logic [2:0]  e_alu;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      cmp("state", 32'(OutState), 32'(e_state));
      cmp("next_state", 32'(NextState), 32'(e_next));
      cmp("pc", 32'(PC_Out), 32'(e_pc));
      cmp("i_addr", 32'(I_Addr), 32'(e_pc));
      cmp("ir", 32'(IR_Out), 32'(e_ir));
      cmp("d_addr", 32'(D_Addr), 32'(e_daddr));
      cmp("d_wr", 32'(D_Wr), 32'(e_dwr));
      cmp("rf_s", 32'(RF_s), 32'(e_rfs));
      cmp("rf_w_en", 32'(RF_W_en), 32'(e_wen));
      cmp("ra", 32'(RF_Ra_Addr), 32'(e_ra));
      cmp("rb", 32'(RF_Rb_Addr), 32'(e_rb));
      cmp("wa", 32'(RF_W_Addr), 32'(e_wa));
      cmp("alu_s0", 32'(ALU_s0), 32'(e_alu));
      cmp("halted", 32'(Halted), 32'(e_halt));
    end
  end

  task automatic base(input logic [3:0] s, input logic [3:0] n);
    e_state = s; e_next = n; e_pc = m_pc; e_ir = m_ir;
    e_daddr = '0; e_dwr = 1'b0; e_rfs = 1'b0; e_wen = 1'b0;
    e_ra = '0; e_rb = '0; e_wa = '0; e_alu = 3'b000; e_halt = 1'b0;
  endtask

  task automatic rnd_inputs();
    I_Valid  = 1'b0;
    I_Data   = 16'($urandom);
    ALU_Zero = 1'($urandom);
    Resume   = 1'($urandom);
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b1;
    ResetN = 1'b0;
    m_pc = '0; m_ir = '0; m_z = 1'b0;
    repeat (2) begin rnd_inputs(); base(S_INIT, S_FETCH); step(); end
    ResetN = 1'b1;
    rnd_inputs(); base(S_INIT, S_FETCH); step();
  endtask

  // Executes one instruction from its first FETCH cycle; returns at the start of the next FETCH.
  // zf < 0 randomises ALU_Zero in ADD/SUB, otherwise forces it.
  task automatic run_instr(input logic [15:0] instr, input int stalls, input int halt_wait,
                           input int zf, input bit force_res, input bit rst_store);
    logic [3:0] op, dn;
    logic       zcap;
    op = instr[15:12];
    for (int i = 0; i < stalls; i++) begin
      rnd_inputs(); base(S_FETCH, S_FETCH); step();
    end
    rnd_inputs(); I_Valid = 1'b1; I_Data = instr; base(S_FETCH, S_DEC); step();
    m_ir = instr;
    m_pc = m_pc + 7'd1;
    case (op)
      4'd1:       dn = S_ST;
      4'd2:       dn = S_LA;
      4'd3:       dn = S_ADD;
      4'd4:       dn = S_SUB;
      4'd5:       dn = S_HALT;
      4'd6, 4'd7: dn = S_JMP;
      default:    dn = S_NOOP;
    endcase
    rnd_inputs(); base(S_DEC, dn); step();
    rnd_inputs();
    case (dn)
      S_LA: begin
        base(S_LA, S_LB); e_daddr = instr[11:4]; e_wa = instr[3:0]; e_rfs = 1'b1; step();
        rnd_inputs();
        base(S_LB, S_FETCH); e_daddr = instr[11:4]; e_wa = instr[3:0]; e_rfs = 1'b1;
        e_wen = 1'b1; step();
      end
      S_ST: begin
        base(S_ST, S_FETCH); e_daddr = instr[11:4]; e_ra = instr[3:0]; e_dwr = 1'b1;
        if (rst_store) begin
          @(negedge Clk); #2;
          ResetN = 1'b0; #1;
          cmp("rst_d_wr", 32'(D_Wr), 32'd0);
          cmp("rst_state", 32'(OutState), 32'(S_INIT));
          cmp("rst_next", 32'(NextState), 32'(S_FETCH));
          cmp("rst_pc", 32'(PC_Out), 32'd0);
          cmp("rst_ir", 32'(IR_Out), 32'd0);
          do_reset();
        end else step();
      end
      S_ADD, S_SUB: begin
        if (zf >= 0) ALU_Zero = zf[0];
        if (force_res) Resume = 1'b1;
        zcap = ALU_Zero;
        base(dn, S_FETCH); e_ra = instr[11:8]; e_rb = instr[7:4]; e_wa = instr[3:0];
        e_alu = (dn == S_ADD) ? 3'b001 : 3'b010; e_wen = 1'b1; step();
        m_z = zcap;
      end
      S_JMP: begin
        base(S_JMP, S_FETCH); step();
        if (op == 4'd6 || m_z) m_pc = instr[6:0];
      end
      S_HALT: begin
        for (int i = 0; i < halt_wait; i++) begin
          Resume = 1'b0; base(S_HALT, S_HALT); e_halt = 1'b1; step(); rnd_inputs();
        end
        Resume = 1'b1; base(S_HALT, S_FETCH); e_halt = 1'b1; step();
      end
      default: begin
        base(S_NOOP, S_FETCH); step();
      end
    endcase
    Resume = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    @(posedge Clk); #1;
    do_reset();
    run_instr(16'h21B5, 0, 0, -1, 1'b0, 1'b0);
    cmp("lit_pc_after_load", 32'(PC_Out), 32'd1);
    cmp("lit_ir_after_load", 32'(IR_Out), 32'h21B5);
    run_instr(16'h3123, 0, 0, 0, 1'b0, 1'b0);
    run_instr(16'h4334, 0, 0, 1, 1'b0, 1'b0);
    run_instr(16'h702A, 0, 0, -1, 1'b0, 1'b0);
    cmp("lit_jz_taken_pc", 32'(PC_Out), 32'h2A);
    run_instr(16'h3123, 0, 0, 0, 1'b0, 1'b0);
    run_instr(16'h702A, 0, 0, -1, 1'b0, 1'b0);
    cmp("lit_jz_not_taken_pc", 32'(PC_Out), 32'h2C);
    run_instr(16'h607F, 0, 0, -1, 1'b0, 1'b0);
    cmp("lit_jmp_pc", 32'(PC_Out), 32'h7F);
    run_instr(16'h0000, 5, 0, -1, 1'b0, 1'b0);
    cmp("lit_pc_wrap", 32'(PC_Out), 32'd0);
    run_instr(16'h5000, 0, 10, -1, 1'b0, 1'b0);
    cmp("lit_pc_after_halt", 32'(PC_Out), 32'd1);
    run_instr(16'h3456, 2, 0, -1, 1'b1, 1'b0);
    run_instr(16'hF123, 0, 0, -1, 1'b0, 1'b0);
    cmp("lit_ir_opF", 32'(IR_Out), 32'hF123);
    run_instr(16'h1AB7, 0, 0, -1, 1'b0, 1'b1);
    run_instr(16'h2C39, 1, 0, -1, 1'b0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 4), -1, 1'b0, 1'b0);
    end
    run_instr(16'h1AB7, 0, 0, -1, 1'b0, 1'b1);
    run_instr(16'h21B5, 0, 0, -1, 1'b0, 1'b0);
    cmp("lit_pc_after_reset_load", 32'(PC_Out), 32'd1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
